seqdiv: RTL and testbench
=========================

SEQDIV -- requirements
Module: seqdiv

Interface
REQ-001 The block SHALL have these ports, clock and reset first: clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-003 startDiv  input  1  start request, level-sensitive; the operation begins after it is released.
REQ-004 A  input  23  dividend fraction field; the hidden leading 1 is implied.
REQ-005 B  input  23  divisor fraction field; the hidden leading 1 is implied.
REQ-006 result  output  25  quotient Q, 1 integer bit and 24 fraction bits.
REQ-007 sticky  output  1  high when the final remainder is nonzero.
REQ-008 doneDiv  output  1  high exactly while the block is in Idle.
REQ-009 The block SHALL have no parameters; all widths are fixed.

Function
REQ-010 Operands SHALL be defined as MA={1'b1,A} and MB={1'b1,B}, each 24 bits with value in [1,2).
REQ-011 On completion, result SHALL equal floor(MA*2^24/MB), and sticky SHALL equal (MA*2^24 mod MB != 0).
REQ-012 The block SHALL implement restoring division with these registers: MAreg and MBreg (24b each), remainder R (25b), quotient Q (25b), and a 5-bit counter cnt.
REQ-013 The state machine SHALL have four states: Idle, Init, Load, Divide.
REQ-014 Idle: doneDiv=1; on startDiv=1 go to Init, otherwise stay in Idle.
REQ-015 Init: Q<=0, cnt<=0, sticky<=0; stay while startDiv=1; go to Load on startDiv=0.
REQ-016 Load: MAreg<=MA, MBreg<=MB, R<={1'b0,MA}; go to Divide.
REQ-017 Divide, once per cycle: if R>=MBreg then q=1 and R'=R-MBreg, else q=0 and R'=R.
REQ-018 Divide, same cycle: R<=R'<<1 (25 bits, no overflow since R'<MBreg), Q<={Q[23:0],q}, cnt<=cnt+1.
REQ-019 Divide SHALL run exactly 25 iterations: when cnt==24, go to Idle and set sticky<=(R'!=0).
REQ-020 Latency SHALL be as follows, with the first rising edge that samples startDiv=0 in Init counted as edge 1.
REQ-021 Load SHALL occur at edge 2, Divide iterations at edges 3..27, and doneDiv SHALL be high after edge 27; that is 27 cycles from start release to done.
REQ-022 startDiv SHALL be ignored in Load and Divide; there is no restart mid-operation.
REQ-023 A and B SHALL be sampled only in Load; changes at any other time have no effect on the operation in progress.
REQ-024 result SHALL be driven directly from Q and sticky from its register.
REQ-025 Both SHALL hold their values in Idle until the next Init.
REQ-026 result SHALL read 0 from the edge after Init is entered.
REQ-027 result SHALL show partial quotients during Divide; consumers sample result only while doneDiv=1.
REQ-028 Q[24] SHALL be 1 when MA>=MB, otherwise Q[24]=0 and Q[23]=1; normalization is left to the caller.
REQ-029 All control decodes SHALL be combinational from the present state; all registers SHALL update only on rising clk.

Reset
REQ-030 When rst=1, regardless of clk, the block SHALL force: state=Idle, MAreg=MBreg=R=Q=0, cnt=0, sticky=0.
REQ-031 Consequently, during and after reset, result=0, sticky=0 and doneDiv=1.
REQ-032 Reset asserted mid-Divide SHALL abort the operation with no partial result retained.
REQ-033 After reset release, the block SHALL remain in Idle until startDiv=1.

Verification
REQ-034 Reset: assert rst with startDiv=0 -> result=0, sticky=0, doneDiv=1; hold with no start -> doneDiv stays 1.
REQ-035 Divide-by-one, unity: A=0, B=0; pulse startDiv -> after 27 cycles result=0x1000000, sticky=0, doneDiv=1.
REQ-036 Max/min: A=0x7FFFFF, B=0 -> result=0x1FFFFFE, sticky=0.
REQ-037 Min/max: A=0, B=0x7FFFFF -> result=0x0800000, sticky=1.
REQ-038 Inexact: A=0, B=0x400000 (1.0/1.5) -> result=0xAAAAAA, sticky=1.
REQ-039 Exact 1.5: A=0x400000, B=0 -> result=0x1800000, sticky=0.
REQ-040 Hold and abort: hold startDiv high 5 cycles -> stay in Init with result=0.
REQ-041 Then toggle startDiv and change A/B during Divide -> no effect on the result.
REQ-042 Then assert rst at iteration 10 -> immediate Idle, result=0, doneDiv=1.

Source files
------------

// File: rtl/seqdiv.sv
// Mantissa divider: 25-iteration restoring division of {1,A} by {1,B}, giving a 1.24 quotient and a sticky bit.
// Latency: 27 rising edges from the first edge that samples startDiv low in Init until doneDiv rises.
// Backpressure: none. startDiv is ignored once the operation is running, and results hold in Idle until the next start.
// Ports:
//   clk      rising-edge clock for all state
//   rst      asynchronous, active-high reset; forces Idle and clears all registers
//   startDiv level-sensitive start request; the divide begins after it is released
//   A, B     23-bit dividend and divisor fractions with an implied leading 1, sampled only in Load
//   result   quotient register Q (1 integer bit, 24 fraction bits); partial values appear while dividing
//   sticky   high when the final remainder is nonzero
//   doneDiv  high exactly while the block is in Idle
module seqdiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        startDiv,
  input  logic [22:0] A,
  input  logic [22:0] B,
  output logic [24:0] result,
  output logic        sticky,
  output logic        doneDiv
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INIT   = 2'd1,
    LOAD   = 2'd2,
    DIVIDE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] ma_q, ma_d;
  logic [23:0] mb_q, mb_d;
  logic [24:0] r_q, r_d;
  logic [24:0] q_q, q_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sticky_q, sticky_d;

  // Restoring step. R < 2*MB and R - MB < MB < 2^24, so a 24-bit
  // subtract yields the exact remainder whenever it is taken. When it is
  // not taken, R < MB, so R[24] is already zero.
  logic        q_bit;
  logic [23:0] r_sub;
  logic [23:0] r_next;

  always_comb begin
    q_bit  = (r_q >= {1'b0, mb_q});
    r_sub  = r_q[23:0] - mb_q;
    r_next = q_bit ? r_sub : r_q[23:0];
  end

  always_comb begin
    state_d  = state_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    r_d      = r_q;
    q_d      = q_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;

    case (state_q)
      IDLE: begin
        if (startDiv) state_d = INIT;
      end

      INIT: begin
        q_d      = '0;
        cnt_d    = '0;
        sticky_d = 1'b0;
        if (!startDiv) state_d = LOAD;
      end

      LOAD: begin
        ma_d    = {1'b1, A};
        mb_d    = {1'b1, B};
        r_d     = {2'b01, A};
        state_d = DIVIDE;
      end

      DIVIDE: begin
        r_d   = {r_next, 1'b0};
        q_d   = {q_q[23:0], q_bit};
        cnt_d = cnt_q + 5'd1;
        // Iteration 25 (cnt == 24) produces the last fraction bit.
        if (cnt_q == 5'd24) begin
          state_d  = IDLE;
          sticky_d = |r_next;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ma_q     <= '0;
      mb_q     <= '0;
      r_q      <= '0;
      q_q      <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      r_q      <= r_d;
      q_q      <= q_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  assign result  = q_q;
  assign sticky  = sticky_q;
  assign doneDiv = (state_q == IDLE);

endmodule

// File: tb/tb_seqdiv.sv
module tb_seqdiv;

  logic        clk;
  logic        rst;
  logic        startDiv;
  logic [22:0] A;
  logic [22:0] B;
  logic [24:0] result;
  logic        sticky;
  logic        doneDiv;

  int n_chk  = 0;
  int n_pass = 0;

  // Scoreboard entries are {sticky, result}.
  logic [25:0] exp_q[$];

  seqdiv dut (
    .clk      (clk),
    .rst      (rst),
    .startDiv (startDiv),
    .A        (A),
    .B        (B),
    .result   (result),
    .sticky   (sticky),
    .doneDiv  (doneDiv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: floor(MA*2^24/MB) and a nonzero-remainder flag.
  function automatic logic [25:0] model(input logic [22:0] a, input logic [22:0] b);
    logic [48:0] num;
    logic [48:0] den;
    logic [48:0] quo;
    logic [48:0] rem;
    num = {1'b0, 1'b1, a, 24'd0};
    den = {25'd0, 1'b1, b};
    quo = num / den;
    rem = num % den;
    return {(rem != 49'd0), quo[24:0]};
  endfunction

  // One division. hold = cycles startDiv stays high; disturb scrambles
  // startDiv, A and B once the operands have been loaded.
  task automatic run_div(input string tag, input logic [22:0] a, input logic [22:0] b,
                         input logic [25:0] exp, input int hold, input bit disturb);
    int n;
    logic [25:0] e;
    A = a;
    B = b;
    exp_q.push_back(exp);
    @(negedge clk);
    startDiv = 1'b1;
    repeat (hold) @(negedge clk);
    if (hold >= 2) begin
      chk({tag, "_init_result"}, 32'(result), 32'd0);
      chk({tag, "_init_done"}, 32'(doneDiv), 32'd0);
    end
    startDiv = 1'b0;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (doneDiv) break;
      if (disturb && n >= 2) begin
        A        = 23'($urandom);
        B        = 23'($urandom);
        startDiv = 1'($urandom);
      end
    end
    startDiv = 1'b0;
    chk({tag, "_latency"}, 32'(n), 32'd27);
    if (exp_q.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_result"}, 32'(result), 32'(e[24:0]));
      chk({tag, "_sticky"}, 32'(sticky), 32'(e[25]));
    end
  endtask

  initial begin
    logic [22:0] ra;
    logic [22:0] rb;
    rst      = 1'b1;
    startDiv = 1'b0;
    A        = '0;
    B        = '0;

    // Asynchronous reset takes effect before any clock edge.
    #1;
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_sticky", 32'(sticky), 32'd0);
    chk("rst_done", 32'(doneDiv), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("idle_hold_done", 32'(doneDiv), 32'd1);
    end

    // Directed operands with hand-derived expectations.
    run_div("unity",   23'h000000, 23'h000000, {1'b0, 25'h1000000}, 1, 1'b0);
    run_div("maxmin",  23'h7FFFFF, 23'h000000, {1'b0, 25'h1FFFFFE}, 1, 1'b0);
    run_div("minmax",  23'h000000, 23'h7FFFFF, {1'b1, 25'h0800000}, 1, 1'b0);
    run_div("inexact", 23'h000000, 23'h400000, {1'b1, 25'h0AAAAAA}, 1, 1'b0);
    run_div("exact15", 23'h400000, 23'h000000, {1'b0, 25'h1800000}, 1, 1'b0);

    // Result holds in Idle.
    repeat (3) @(negedge clk);
    chk("idle_keep_result", 32'(result), 32'h1800000);

    // Long start hold, then disturbed inputs during Divide.
    run_div("hold_disturb", 23'h000000, 23'h400000, {1'b1, 25'h0AAAAAA}, 5, 1'b1);

    // Randomized operands checked against the reference model.
    for (int i = 0; i < 12; i++) begin
      ra = 23'($urandom);
      rb = 23'($urandom);
      run_div("rand", ra, rb, model(ra, rb), 1 + (i % 3), (i % 2) == 1);
    end

    // Abort: reset around the tenth iteration.
    A = 23'h123456;
    B = 23'h654321;
    @(negedge clk);
    startDiv = 1'b1;
    @(negedge clk);
    startDiv = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_busy", 32'(doneDiv), 32'd0);
    rst = 1'b1;
    #1;
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_sticky", 32'(sticky), 32'd0);
    chk("abort_done", 32'(doneDiv), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("post_abort_done", 32'(doneDiv), 32'd1);
      chk("post_abort_result", 32'(result), 32'd0);
    end

    // Block still works after the abort.
    run_div("after_abort", 23'h7FFFFF, 23'h000000, {1'b0, 25'h1FFFFFE}, 2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
